// File: rtl/serial2region_pkg.sv
// -----------------------------------------------------------------------------
// serial2region_pkg
// Shared definitions for the serial region receiver:
//   - default coordinate width and FIFO depth
//   - receiver FSM state encoding
//   - region pair struct {x, y}
// -----------------------------------------------------------------------------
package serial2region_pkg;

  localparam int COORD_WIDTH_DEF = 9;
  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int BIT_CNT_W       = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RECV = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef struct packed {
    logic [COORD_WIDTH_DEF-1:0] x;
    logic [COORD_WIDTH_DEF-1:0] y;
  } region_t;

endpackage

// File: rtl/serial2region_sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a registered head: o_valid/o_data are flops that
// always present the oldest entry, so a pop is followed by the next entry in
// the very next cycle. A push is accepted when not full, or when full and a
// pop happens in the same cycle.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   i_push, i_data     write request and data
//   i_pop              consumer accepts the head (ignored when o_valid = 0)
//   o_valid, o_data    registered head
//   o_full, o_empty    occupancy flags
// -----------------------------------------------------------------------------
module sync_fifo
  import serial2region_pkg::*;
#(
  parameter int WIDTH = 2 * COORD_WIDTH_DEF,
  parameter int DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [AW-1:0]    w_wr_ptr_next, w_rd_ptr_next;
  logic [CW-1:0]    r_count, w_count_next;
  logic             w_do_push, w_do_pop;
  logic             r_valid;
  logic [WIDTH-1:0] r_head;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_valid   = r_valid;
  assign o_data    = r_head;
  assign w_do_pop  = i_pop && r_valid;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_comb begin
    w_wr_ptr_next = w_do_push ? ptr_inc(r_wr_ptr) : r_wr_ptr;
    w_rd_ptr_next = w_do_pop  ? ptr_inc(r_rd_ptr) : r_rd_ptr;
    w_count_next  = r_count;
    case ({w_do_push, w_do_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  // Storage has no reset so it can map onto RAM resources.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_count  <= w_count_next;
      r_valid  <= (w_count_next != '0);
      if (w_count_next != '0) begin
        // The next head is the entry being written right now when the
        // write lands exactly on the new read slot (empty or single entry).
        if (w_do_push && (w_rd_ptr_next == r_wr_ptr)) begin
          r_head <= i_data;
        end else begin
          r_head <= r_mem[w_rd_ptr_next];
        end
      end
    end
  end

endmodule

// File: rtl/serial2region.sv
// -----------------------------------------------------------------------------
// serial2region
// Deserializing receiver for the region-proposal link. Requests a frame from
// the serializer, oversamples its slow bit clock and x/y lanes, rebuilds
// LSB-first coordinate pairs and queues them for the CNN consumer.
// Optional feature macro: SERIAL2REGION_BOUND_CHECK_EN (drops pairs outside
// FRAME_W x FRAME_H and adds output bound_drop_cnt).
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   frame_req                            pulse: fetch the next frame
//   cnn_rd_region                        read request to the serializer
//   cnn_region_done/valid/x_bit/y_bit    async serializer lanes
//   cnn_region_clk                       async serializer bit clock (data)
//   region_out_valid/ready/x/y           pair output handshake
//   frame_done, frame_count              end-of-frame pulse and pair count
//   err_framing, err_overflow            sticky errors, cleared by frame_req
// -----------------------------------------------------------------------------
module serial2region
  import serial2region_pkg::*;
#(
  parameter int COORD_WIDTH = COORD_WIDTH_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
`ifdef SERIAL2REGION_BOUND_CHECK_EN
  ,
  parameter int FRAME_W     = 320,
  parameter int FRAME_H     = 240
`endif
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   frame_req,
  output logic                   cnn_rd_region,
  input  logic                   cnn_region_done,
  input  logic                   cnn_region_valid,
  input  logic                   cnn_region_x_bit,
  input  logic                   cnn_region_y_bit,
  input  logic                   cnn_region_clk,
  output logic                   region_out_valid,
  input  logic                   region_out_ready,
  output logic [COORD_WIDTH-1:0] region_out_x,
  output logic [COORD_WIDTH-1:0] region_out_y,
  output logic                   frame_done,
  output logic [4:0]             frame_count,
  output logic                   err_framing,
  output logic                   err_overflow
`ifdef SERIAL2REGION_BOUND_CHECK_EN
  ,
  output logic [7:0]             bound_drop_cnt
`endif
);

  localparam int PW = 2 * COORD_WIDTH;

  // ---------------------------------------------------------------- sync
  logic [4:0] w_async;
  logic [4:0] r_meta, r_sync;
  logic       r_clk_d, r_done_d;
  logic       w_sclk, w_done, w_valid, w_x_bit, w_y_bit;
  logic       w_sample, w_done_fall;

  assign w_async = {cnn_region_clk, cnn_region_done, cnn_region_valid,
                    cnn_region_x_bit, cnn_region_y_bit};
  assign {w_sclk, w_done, w_valid, w_x_bit, w_y_bit} = r_sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta   <= '0;
      r_sync   <= '0;
      r_clk_d  <= 1'b0;
      r_done_d <= 1'b0;
    end else begin
      r_meta   <= w_async;
      r_sync   <= r_meta;
      r_clk_d  <= w_sclk;
      r_done_d <= w_done;
    end
  end

  // Serializer launches on its rising edge, so its falling edge is mid-bit.
  assign w_sample    = r_clk_d & ~w_sclk;
  assign w_done_fall = r_done_d & ~w_done;

  // ---------------------------------------------------------------- FSM
  state_t r_state, w_state_next;
  logic   w_frame_start;
  logic   w_fifo_empty, w_fifo_full;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    cnn_rd_region = 1'b0;
    frame_done    = 1'b0;
    w_frame_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (frame_req && w_fifo_empty) begin
          w_state_next  = ST_REQ;
          w_frame_start = 1'b1;
        end
      end
      ST_REQ: begin
        cnn_rd_region = 1'b1;
        if (w_done_fall)              w_state_next = ST_DONE;
        else if (w_sample && w_valid) w_state_next = ST_RECV;
      end
      ST_RECV: begin
        if (w_done_fall) w_state_next = ST_DONE;
      end
      ST_DONE: begin
        frame_done   = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- assembly
  logic [COORD_WIDTH-1:0] r_x_sr, r_y_sr;
  logic [BIT_CNT_W-1:0]   r_bit_cnt;
  logic                   r_push;
  logic [PW-1:0]          r_push_data;
  logic                   w_active, w_shift_en, w_word_end, w_word_ok, w_abort;

  assign w_active   = (r_state == ST_REQ) || (r_state == ST_RECV);
  assign w_shift_en = w_sample && w_valid && w_active;
  assign w_word_end = w_sample && !w_valid && (r_state == ST_RECV) && (r_bit_cnt != '0);
  assign w_word_ok  = (r_bit_cnt == BIT_CNT_W'(COORD_WIDTH));
  // A completed word at the done edge still gets pushed; only partials abort.
  assign w_abort    = w_done_fall && (r_state == ST_RECV) && (r_bit_cnt != '0) && !w_word_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x_sr      <= '0;
      r_y_sr      <= '0;
      r_bit_cnt   <= '0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      err_framing <= 1'b0;
    end else begin
      r_push <= w_word_end && w_word_ok;
      if (w_word_end) r_push_data <= {r_x_sr, r_y_sr};

      if (w_frame_start) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_x_sr <= {w_x_bit, r_x_sr[COORD_WIDTH-1:1]};
        r_y_sr <= {w_y_bit, r_y_sr[COORD_WIDTH-1:1]};
        if (r_bit_cnt != {BIT_CNT_W{1'b1}}) r_bit_cnt <= r_bit_cnt + 1'b1;
      end else if (w_word_end || w_abort) begin
        r_bit_cnt <= '0;
      end

      if (w_frame_start)                              err_framing <= 1'b0;
      else if ((w_word_end && !w_word_ok) || w_abort) err_framing <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- push path
  logic [COORD_WIDTH-1:0] w_push_x, w_push_y;
  logic                   w_in_bounds, w_fifo_push, w_pop, w_push_ok, w_overflow;
  logic [PW-1:0]          w_head;

  assign w_push_x = r_push_data[PW-1:COORD_WIDTH];
  assign w_push_y = r_push_data[COORD_WIDTH-1:0];

`ifdef SERIAL2REGION_BOUND_CHECK_EN
  logic [31:0] w_x_ext, w_y_ext;
  assign w_x_ext     = 32'(w_push_x);
  assign w_y_ext     = 32'(w_push_y);
  assign w_in_bounds = (w_x_ext < 32'(FRAME_W)) && (w_y_ext < 32'(FRAME_H));
`else
  assign w_in_bounds = 1'b1;
`endif

  assign w_fifo_push = r_push && w_in_bounds;
  assign w_pop       = region_out_valid && region_out_ready;
  assign w_push_ok   = w_fifo_push && (!w_fifo_full || w_pop);
  assign w_overflow  = w_fifo_push && w_fifo_full && !w_pop;

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset_n),
    .i_push  (w_fifo_push),
    .i_data  (r_push_data),
    .i_pop   (region_out_ready),
    .o_valid (region_out_valid),
    .o_data  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  assign region_out_x = w_head[PW-1:COORD_WIDTH];
  assign region_out_y = w_head[COORD_WIDTH-1:0];

  // ---------------------------------------------------------------- counters
  logic [4:0] r_frame_cnt, w_frame_cnt_inc;

  // Saturating; a push landing in the DONE cycle is still counted.
  assign w_frame_cnt_inc = (w_push_ok && (r_frame_cnt != 5'd31)) ?
                           r_frame_cnt + 5'd1 : r_frame_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt  <= '0;
      frame_count  <= '0;
      err_overflow <= 1'b0;
    end else begin
      if (r_state == ST_DONE) begin
        frame_count <= w_frame_cnt_inc;
        r_frame_cnt <= '0;
      end else if (w_frame_start) begin
        r_frame_cnt <= '0;
      end else begin
        r_frame_cnt <= w_frame_cnt_inc;
      end

      if (w_frame_start)   err_overflow <= 1'b0;
      else if (w_overflow) err_overflow <= 1'b1;
    end
  end

`ifdef SERIAL2REGION_BOUND_CHECK_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bound_drop_cnt <= '0;
    end else if (w_frame_start) begin
      bound_drop_cnt <= '0;
    end else if (r_push && !w_in_bounds && (bound_drop_cnt != 8'hFF)) begin
      bound_drop_cnt <= bound_drop_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/serial2region.md
# serial2region

Deserializing receiver on the CNN side of the region-proposal link. It requests a frame of regions from the region serializer and samples the slow serial region clock and x/y bit lanes in the system clock domain. It reassembles LSB-first coordinates into parallel (x, y) pairs and buffers them in a FIFO. CNN control logic drains pairs through a valid/ready handshake and is told when a frame has ended.

## Interface
- COORD_WIDTH, 9: bits per coordinate on both lanes; x and y share one width.
- FIFO_DEPTH, 16: region pair storage; must be ≥ 2×max objects, i.e. 16.
- FRAME_W, 320: x bound, used only under the bound-check option.
- FRAME_H, 240: y bound, used only under the bound-check option.

- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- frame_req  in  1  one-cycle pulse from CNN control: fetch the next frame of regions.
- cnn_rd_region  out  1  read request to the serializer.
- cnn_region_done  in  1  serializer frame-active level; async, synchronized here.
- cnn_region_valid  in  1  bit-valid level; async.
- cnn_region_x_bit  in  1  x serial lane; async.
- cnn_region_y_bit  in  1  y serial lane; async.
- cnn_region_clk  in  1  serializer bit clock; async, treated as data.
- region_out_valid  out  1  FIFO head valid.
- region_out_ready  in  1  consumer accepts the head.
- region_out_x  out  COORD_WIDTH  head x.
- region_out_y  out  COORD_WIDTH  head y.
- frame_done  out  1  one-cycle pulse at end of frame.
- frame_count  out  5  regions pushed in the last frame; held until the next frame_done.
- err_framing  out  1  sticky; cleared by frame_req.
- err_overflow  out  1  sticky; cleared by frame_req.

## Operation
- Sync: each of the 5 async inputs passes through 2 flops; an extra flop on the synced clock gives edge detection.
- Sample point: a falling edge of the synced cnn_region_clk. The serializer launches bits on rising edges, so this sample is mid-bit.
- At every sample point:
  - Synced valid = 1: shift x_sr ← {x_bit, x_sr[W-1:1]}, same for y; bit_cnt+1, saturating at 31.
  - Synced valid = 0 and bit_cnt ≠ 0: if bit_cnt == COORD_WIDTH, push {x_sr, y_sr}; otherwise set err_framing and discard. Then clear bit_cnt.
- FSM states:
  - IDLE: cnn_rd_region = 0. frame_req with the FIFO empty → REQ. frame_req with the FIFO not empty is ignored, and err flags are not cleared.
  - REQ: cnn_rd_region = 1. First sample with valid = 1 → RECV, cnn_rd_region = 0. Synced done falling here → DONE.
  - RECV: assemble and push as above. Synced done falling edge → DONE. A partial word (bit_cnt ≠ 0) at that edge sets err_framing and is discarded.
  - DONE: frame_done = 1 for one cycle, latch frame_count, clear the per-frame counter, go to IDLE.
- FIFO full at push: drop the pair and set err_overflow. The count is not incremented.
- Same-cycle push and pop are both allowed, including when the FIFO is full: the pop frees a slot, so the push succeeds.
- Reset values: cnn_rd_region, region_out_valid, frame_done, err_framing and err_overflow are 0. frame_count, region_out_x and region_out_y are 0. FIFO is empty, FSM is in IDLE. Reset is allowed mid-frame; the serializer then completes its frame unobserved.

## Timing
- Input-to-sample latency: 3 clk (2 sync flops + 1 edge-detect flop).
- Push happens in the clk after the valid = 0 sample. region_out_valid rises 1 clk after the push (registered head).
- Pop happens on region_out_valid && region_out_ready. The next head is presented in the following cycle with no bubble.
- cnn_rd_region must stay high for ≥ 1 full serializer clock period. It is held until the first valid bit is sampled.
- Minimum serializer half-period: 4 clk. The default divisor gives 6.

## Configuration
- SERIAL2REGION_BOUND_CHECK_EN:
  - Defined: a pair with x ≥ FRAME_W or y ≥ FRAME_H is dropped at push and not counted. An 8-bit saturating counter of drops is exposed on an extra output, bound_drop_cnt, cleared by frame_req.
  - Undefined: no comparison, every well-framed pair is pushed, and the port does not exist.

## Structure
- Package serial2region_pkg holds:
  - the COORD_WIDTH default;
  - the state enum {IDLE, REQ, RECV, DONE};
  - the region pair struct {x, y}.
- One sub-module, sync_fifo: parametric width and depth, registered head, full/empty flags.

## Test plan
- One frame with pairs (5, 7) and (319, 239) at divisor 5 → frame_done pulse; frame_count = 2; two pops yield exactly those pairs in order; no errors.
- Valid held for 8 bits instead of 9 → err_framing = 1, nothing pushed, frame_count = 0.
- 17 pairs sent with region_out_ready = 0 → 16 stored; err_overflow = 1; frame_count = 16.
- frame_req while the FIFO is non-empty → cnn_rd_region stays 0. After the FIFO is drained, a new frame_req → cnn_rd_region = 1.
- reset_n asserted mid-word (bit 4) → all outputs return to their reset values immediately. The next frame after release is received correctly.
- With the bound check enabled, pair (320, 10) → dropped; bound_drop_cnt = 1; frame_count excludes it.
